// File: rtl/ctrl_pkg.sv
// Shared widths, state encodings, opcode/funct/ALU constants and CTRL bit map for the cs147sec05 control unit.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (adds the HALT state used by the illegal-instruction trap).
package ctrl_pkg;

  localparam int CTRL_W  = 32;
  localparam int INSTR_W = 32;
  localparam int STATE_W = 3;
  localparam int ALU_W   = 6;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
`ifdef CTRL_ILLEGAL_TRAP_EN
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
`else
    ST_WRITEBACK = 3'd4
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_MULI  = 6'h1D;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_JMP   = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_PUSH  = 6'h1B;
  localparam logic [5:0] OP_POP   = 6'h1C;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_MUL = 6'h2C;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLL = 6'h01;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;

  localparam logic [ALU_W-1:0] ALU_NOP = 6'd0;
  localparam logic [ALU_W-1:0] ALU_ADD = 6'd1;
  localparam logic [ALU_W-1:0] ALU_SUB = 6'd2;
  localparam logic [ALU_W-1:0] ALU_MUL = 6'd3;
  localparam logic [ALU_W-1:0] ALU_SRL = 6'd4;
  localparam logic [ALU_W-1:0] ALU_SLL = 6'd5;
  localparam logic [ALU_W-1:0] ALU_AND = 6'd6;
  localparam logic [ALU_W-1:0] ALU_OR  = 6'd7;
  localparam logic [ALU_W-1:0] ALU_NOR = 6'd8;
  localparam logic [ALU_W-1:0] ALU_SLT = 6'd9;

  localparam int B_PC_LOAD   = 0;
  localparam int B_PC_SEL_1  = 1;
  localparam int B_PC_SEL_2  = 2;
  localparam int B_PC_SEL_3  = 3;
  localparam int B_MEM_R     = 4;
  localparam int B_MEM_W     = 5;
  localparam int B_R1_SEL_1  = 6;
  localparam int B_REG_R     = 7;
  localparam int B_REG_W     = 8;
  localparam int B_WA_SEL_1  = 9;
  localparam int B_WA_SEL_2  = 10;
  localparam int B_WA_SEL_3  = 11;
  localparam int B_WD_SEL_1  = 12;
  localparam int B_WD_SEL_2  = 13;
  localparam int B_WD_SEL_3  = 14;
  localparam int B_SP_LOAD   = 15;
  localparam int B_OP1_SEL_1 = 16;
  localparam int B_OP2_SEL_1 = 17;
  localparam int B_OP2_SEL_2 = 18;
  localparam int B_OP2_SEL_3 = 19;
  localparam int B_OP2_SEL_4 = 20;
  localparam int B_ALU_LSB   = 21;
  localparam int B_MA_SEL_1  = 27;
  localparam int B_MA_SEL_2  = 28;
  localparam int B_MD_SEL_1  = 29;
  localparam int B_IR_LOAD   = 30;

  // ALU code for an R-type funct; ALU_NOP marks jr and undefined functs.
  function automatic logic [ALU_W-1:0] rtype_alu(input logic [5:0] funct);
    logic [ALU_W-1:0] op;
    case (funct)
      FN_ADD:  op = ALU_ADD;
      FN_SUB:  op = ALU_SUB;
      FN_MUL:  op = ALU_MUL;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_NOR:  op = ALU_NOR;
      FN_SLT:  op = ALU_SLT;
      FN_SLL:  op = ALU_SLL;
      FN_SRL:  op = ALU_SRL;
      default: op = ALU_NOP;
    endcase
    return op;
  endfunction

  function automatic logic is_legal(input logic [5:0] opcode, input logic [5:0] funct);
    logic ok;
    case (opcode)
      OP_RTYPE: ok = (funct == FN_JR) || (rtype_alu(funct) != ALU_NOP);
      OP_ADDI, OP_MULI, OP_ANDI, OP_ORI, OP_LUI, OP_SLTI, OP_BEQ, OP_BNE,
      OP_LW, OP_SW, OP_JMP, OP_JAL, OP_PUSH, OP_POP: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational mapping of (state, ir, zero_q) to the 32-bit data-path control word.
// Undefined instructions decode as no-ops that only advance the PC in WRITEBACK.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  state_t             state,
  input  logic [INSTR_W-1:0] ir,
  input  logic               zero_q,
  output logic [CTRL_W-1:0]  ctrl
);

  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             unused_ir_bits;
  logic [ALU_W-1:0] exe_alu;
  logic             use_r2, use_shamt, use_one, use_simm, use_sp;
  logic             wr_rd, wr_rt, wr_r31, wr_r0, wd_mem, wd_lui;
  logic             is_jr, is_jump, is_beq, is_bne, is_lw, is_sw, is_push, is_pop;
  logic             writes_reg;

  assign opcode         = ir[31:26];
  assign funct          = ir[5:0];
  assign unused_ir_bits = ^ir[25:6];

  always_comb begin
    exe_alu   = ALU_NOP;
    use_r2    = 1'b0;
    use_shamt = 1'b0;
    use_one   = 1'b0;
    use_simm  = 1'b0;
    use_sp    = 1'b0;
    wr_rd     = 1'b0;
    wr_rt     = 1'b0;
    wr_r31    = 1'b0;
    wr_r0     = 1'b0;
    wd_mem    = 1'b0;
    wd_lui    = 1'b0;
    is_jr     = 1'b0;
    is_jump   = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    is_push   = 1'b0;
    is_pop    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        exe_alu = rtype_alu(funct);
        is_jr   = (funct == FN_JR);
        if (exe_alu != ALU_NOP) begin
          wr_rd = 1'b1;
          if (funct == FN_SLL || funct == FN_SRL) use_shamt = 1'b1;
          else use_r2 = 1'b1;
        end
      end
      OP_ADDI: begin exe_alu = ALU_ADD; use_simm = 1'b1; wr_rt = 1'b1; end
      OP_MULI: begin exe_alu = ALU_MUL; use_simm = 1'b1; wr_rt = 1'b1; end
      OP_SLTI: begin exe_alu = ALU_SLT; use_simm = 1'b1; wr_rt = 1'b1; end
      OP_ANDI: begin exe_alu = ALU_AND; wr_rt = 1'b1; end
      OP_ORI:  begin exe_alu = ALU_OR;  wr_rt = 1'b1; end
      OP_LUI:  begin wr_rt = 1'b1; wd_lui = 1'b1; end
      OP_BEQ:  begin exe_alu = ALU_SUB; use_r2 = 1'b1; is_beq = 1'b1; end
      OP_BNE:  begin exe_alu = ALU_SUB; use_r2 = 1'b1; is_bne = 1'b1; end
      OP_LW:   begin exe_alu = ALU_ADD; use_simm = 1'b1; wr_rt = 1'b1; wd_mem = 1'b1; is_lw = 1'b1; end
      OP_SW:   begin exe_alu = ALU_ADD; use_simm = 1'b1; is_sw = 1'b1; end
      OP_JMP:  is_jump = 1'b1;
      OP_JAL:  begin is_jump = 1'b1; wr_r31 = 1'b1; end
      // push pre-computes SP-1 and pop computes SP+1, both via the constant-1 operand
      OP_PUSH: begin exe_alu = ALU_SUB; use_sp = 1'b1; use_one = 1'b1; is_push = 1'b1; end
      OP_POP:  begin exe_alu = ALU_ADD; use_sp = 1'b1; use_one = 1'b1; is_pop = 1'b1; wr_r0 = 1'b1; wd_mem = 1'b1; end
      default: ;
    endcase
  end

  assign writes_reg = wr_rd | wr_rt | wr_r31 | wr_r0;

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl[B_MEM_R]    = 1'b1;
        ctrl[B_MA_SEL_2] = 1'b1;
        ctrl[B_IR_LOAD]  = 1'b1;
      end
      ST_DECODE: begin
        ctrl[B_REG_R]    = 1'b1;
        ctrl[B_R1_SEL_1] = !is_push;
      end
      ST_EXECUTE: begin
        ctrl[B_REG_R]                 = 1'b1;
        ctrl[B_R1_SEL_1]              = !is_push;
        ctrl[B_OP1_SEL_1]             = use_sp;
        ctrl[B_OP2_SEL_1]             = use_shamt;
        ctrl[B_OP2_SEL_2]             = use_simm;
        ctrl[B_OP2_SEL_3]             = use_shamt | use_one;
        ctrl[B_OP2_SEL_4]             = use_r2;
        ctrl[B_ALU_LSB +: ALU_W]      = exe_alu;
        ctrl[B_SP_LOAD]               = is_pop;
      end
      ST_MEMORY: begin
        ctrl[B_MEM_R]    = is_lw | is_pop;
        ctrl[B_MEM_W]    = is_sw | is_push;
        ctrl[B_MA_SEL_1] = is_push | is_pop;
        ctrl[B_MD_SEL_1] = is_push;
      end
      ST_WRITEBACK: begin
        ctrl[B_PC_LOAD]  = 1'b1;
        ctrl[B_PC_SEL_1] = !is_jr;
        ctrl[B_PC_SEL_2] = (is_beq & zero_q) | (is_bne & !zero_q);
        ctrl[B_PC_SEL_3] = !is_jump;
        ctrl[B_REG_W]    = writes_reg;
        ctrl[B_WA_SEL_1] = wr_rt;
        ctrl[B_WA_SEL_2] = wr_r31;
        ctrl[B_WA_SEL_3] = wr_rd | wr_rt;
        ctrl[B_WD_SEL_1] = wd_mem;
        ctrl[B_WD_SEL_2] = wd_lui;
        ctrl[B_WD_SEL_3] = writes_reg & !wr_r31;
        ctrl[B_SP_LOAD]  = is_push;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Five-state sequencing controller for the cs147sec05 processor: FSM, ir/zero_q capture and ILLEGAL flag.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (undefined instructions set ILLEGAL and halt until RST).
module control_unit
  import ctrl_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic [INSTR_W-1:0]  INSTRUCTION,
  input  logic                ZERO,
  output logic [CTRL_W-1:0]   CTRL,
  output logic [STATE_W-1:0]  STATE,
  output logic                ILLEGAL
);

  state_t             state;
  state_t             state_next;
  logic [INSTR_W-1:0] ir;
  logic               zero_q;
  logic [CTRL_W-1:0]  ctrl_raw;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_FETCH;
      ir     <= '0;
      zero_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_FETCH)   ir     <= INSTRUCTION;
      if (state == ST_EXECUTE) zero_q <= ZERO;
    end
  end

  // Unused encodings fall into default and recover to FETCH.
  always_comb begin
    state_next = ST_FETCH;
    case (state)
      ST_FETCH: state_next = ST_DECODE;
`ifdef CTRL_ILLEGAL_TRAP_EN
      ST_DECODE: state_next = is_legal(ir[31:26], ir[5:0]) ? ST_EXECUTE : ST_HALT;
      ST_HALT:   state_next = ST_HALT;
`else
      ST_DECODE: state_next = ST_EXECUTE;
`endif
      ST_EXECUTE:   state_next = ST_MEMORY;
      ST_MEMORY:    state_next = ST_WRITEBACK;
      ST_WRITEBACK: state_next = ST_FETCH;
      default:      state_next = ST_FETCH;
    endcase
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge CLK) begin
    if (RST) illegal_q <= 1'b0;
    else if (state == ST_DECODE && !is_legal(ir[31:26], ir[5:0])) illegal_q <= 1'b1;
  end

  assign ILLEGAL = illegal_q;
`else
  assign ILLEGAL = 1'b0;
`endif

  ctrl_decoder u_decoder (
    .state  (state),
    .ir     (ir),
    .zero_q (zero_q),
    .ctrl   (ctrl_raw)
  );

  assign CTRL  = RST ? '0 : ctrl_raw;
  assign STATE = state;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction vector table driven through all five states,
// plus hand sequences for reset, mid-instruction abort and (with CTRL_ILLEGAL_TRAP_EN) the halt trap.
module tb_control_unit;

  localparam logic [31:0] PC_LOAD   = 32'h1 << 0;
  localparam logic [31:0] PC_SEL_1  = 32'h1 << 1;
  localparam logic [31:0] PC_SEL_2  = 32'h1 << 2;
  localparam logic [31:0] PC_SEL_3  = 32'h1 << 3;
  localparam logic [31:0] MEM_R     = 32'h1 << 4;
  localparam logic [31:0] MEM_W     = 32'h1 << 5;
  localparam logic [31:0] R1_SEL_1  = 32'h1 << 6;
  localparam logic [31:0] REG_R     = 32'h1 << 7;
  localparam logic [31:0] REG_W     = 32'h1 << 8;
  localparam logic [31:0] WA_SEL_1  = 32'h1 << 9;
  localparam logic [31:0] WA_SEL_2  = 32'h1 << 10;
  localparam logic [31:0] WA_SEL_3  = 32'h1 << 11;
  localparam logic [31:0] WD_SEL_1  = 32'h1 << 12;
  localparam logic [31:0] WD_SEL_2  = 32'h1 << 13;
  localparam logic [31:0] WD_SEL_3  = 32'h1 << 14;
  localparam logic [31:0] SP_LOAD   = 32'h1 << 15;
  localparam logic [31:0] OP1_SEL_1 = 32'h1 << 16;
  localparam logic [31:0] OP2_SEL_1 = 32'h1 << 17;
  localparam logic [31:0] OP2_SEL_2 = 32'h1 << 18;
  localparam logic [31:0] OP2_SEL_3 = 32'h1 << 19;
  localparam logic [31:0] OP2_SEL_4 = 32'h1 << 20;
  localparam logic [31:0] MA_SEL_1  = 32'h1 << 27;
  localparam logic [31:0] MA_SEL_2  = 32'h1 << 28;
  localparam logic [31:0] MD_SEL_1  = 32'h1 << 29;
  localparam logic [31:0] IR_LOAD   = 32'h1 << 30;

  localparam logic [31:0] FETCH_W = MEM_R | MA_SEL_2 | IR_LOAD;
  localparam logic [31:0] DEC     = REG_R | R1_SEL_1;
  localparam logic [31:0] EXE_R   = DEC | OP2_SEL_4;
  localparam logic [31:0] NEXT_PC = PC_LOAD | PC_SEL_1 | PC_SEL_3;
  localparam logic [31:0] WB_RD   = NEXT_PC | REG_W | WA_SEL_3 | WD_SEL_3;
  localparam logic [31:0] WB_RT   = NEXT_PC | REG_W | WA_SEL_1 | WA_SEL_3 | WD_SEL_3;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        zero;
    logic [31:0] dec;
    logic [31:0] exe;
    logic [31:0] mem;
    logic [31:0] wb;
  } vec_t;

  typedef struct {
    string       name;
    logic [2:0]  state;
    logic [31:0] ctrl;
    logic        illegal;
  } exp_t;

  logic        CLK;
  logic        RST;
  logic [31:0] INSTRUCTION;
  logic        ZERO;
  logic [31:0] CTRL;
  logic [2:0]  STATE;
  logic        ILLEGAL;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  control_unit dut (
    .CLK         (CLK),
    .RST         (RST),
    .INSTRUCTION (INSTRUCTION),
    .ZERO        (ZERO),
    .CTRL        (CTRL),
    .STATE       (STATE),
    .ILLEGAL     (ILLEGAL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] alu(input logic [5:0] code);
    return {5'b0, code, 21'b0};
  endfunction

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL scoreboard: got empty queue, required an expected entry");
      return;
    end
    e = sb.pop_front();
    tests++;
    if (STATE !== e.state) begin
      fails++;
      $display("[TB] FAIL %s STATE: got %0d, required %0d", e.name, STATE, e.state);
    end
    tests++;
    if (CTRL !== e.ctrl) begin
      fails++;
      $display("[TB] FAIL %s CTRL: got %h, required %h", e.name, CTRL, e.ctrl);
    end
    tests++;
    if (ILLEGAL !== e.illegal) begin
      fails++;
      $display("[TB] FAIL %s ILLEGAL: got %b, required %b", e.name, ILLEGAL, e.illegal);
    end
  endtask

  // Called just after a rising edge: drives one cycle of inputs, records the expectation, checks at the falling edge.
  task automatic applyStimulus(input string name, input logic [31:0] instr, input logic zero,
                               input logic rst, input logic [2:0] exp_state,
                               input logic [31:0] exp_ctrl, input logic exp_ill);
    INSTRUCTION = instr;
    ZERO        = zero;
    RST         = rst;
    sb.push_back('{name, exp_state, exp_ctrl, exp_ill});
    @(negedge CLK);
    checkOutput();
    @(posedge CLK);
    #1;
  endtask

  task automatic runInstr(input vec_t v);
    applyStimulus({v.name, "/fetch"},     v.instr,   !v.zero, 1'b0, 3'd0, FETCH_W, 1'b0);
    applyStimulus({v.name, "/decode"},    $urandom, !v.zero, 1'b0, 3'd1, v.dec,   1'b0);
    applyStimulus({v.name, "/execute"},   $urandom, v.zero,  1'b0, 3'd2, v.exe,   1'b0);
    applyStimulus({v.name, "/memory"},    $urandom, !v.zero, 1'b0, 3'd3, v.mem,   1'b0);
    applyStimulus({v.name, "/writeback"}, $urandom, !v.zero, 1'b0, 3'd4, v.wb,    1'b0);
  endtask

  initial begin
    vecs.push_back('{"add",  32'h00221820, 1'b0, DEC, EXE_R | alu(1), 32'h0, WB_RD});
    vecs.push_back('{"sub",  32'h00221822, 1'b1, DEC, EXE_R | alu(2), 32'h0, WB_RD});
    vecs.push_back('{"mul",  32'h0022182C, 1'b0, DEC, EXE_R | alu(3), 32'h0, WB_RD});
    vecs.push_back('{"and",  32'h00221824, 1'b0, DEC, EXE_R | alu(6), 32'h0, WB_RD});
    vecs.push_back('{"or",   32'h00221825, 1'b0, DEC, EXE_R | alu(7), 32'h0, WB_RD});
    vecs.push_back('{"nor",  32'h00221827, 1'b0, DEC, EXE_R | alu(8), 32'h0, WB_RD});
    vecs.push_back('{"slt",  32'h0022182A, 1'b0, DEC, EXE_R | alu(9), 32'h0, WB_RD});
    vecs.push_back('{"sll",  32'h00021901, 1'b0, DEC, DEC | OP2_SEL_3 | OP2_SEL_1 | alu(5), 32'h0, WB_RD});
    vecs.push_back('{"srl",  32'h00021902, 1'b0, DEC, DEC | OP2_SEL_3 | OP2_SEL_1 | alu(4), 32'h0, WB_RD});
    vecs.push_back('{"jr",   32'h03E00008, 1'b0, DEC, DEC, 32'h0, PC_LOAD | PC_SEL_3});
    vecs.push_back('{"addi", 32'h20220005, 1'b0, DEC, DEC | OP2_SEL_2 | alu(1), 32'h0, WB_RT});
    vecs.push_back('{"muli", 32'h74220005, 1'b0, DEC, DEC | OP2_SEL_2 | alu(3), 32'h0, WB_RT});
    vecs.push_back('{"andi", 32'h30220005, 1'b0, DEC, DEC | alu(6), 32'h0, WB_RT});
    vecs.push_back('{"ori",  32'h34220005, 1'b0, DEC, DEC | alu(7), 32'h0, WB_RT});
    vecs.push_back('{"slti", 32'h28220005, 1'b0, DEC, DEC | OP2_SEL_2 | alu(9), 32'h0, WB_RT});
    vecs.push_back('{"lui",  32'h3C021234, 1'b0, DEC, DEC, 32'h0, WB_RT | WD_SEL_2});
    vecs.push_back('{"beq_z1", 32'h10220003, 1'b1, DEC, EXE_R | alu(2), 32'h0, NEXT_PC | PC_SEL_2});
    vecs.push_back('{"beq_z0", 32'h10220003, 1'b0, DEC, EXE_R | alu(2), 32'h0, NEXT_PC});
    vecs.push_back('{"bne_z0", 32'h14220003, 1'b0, DEC, EXE_R | alu(2), 32'h0, NEXT_PC | PC_SEL_2});
    vecs.push_back('{"bne_z1", 32'h14220003, 1'b1, DEC, EXE_R | alu(2), 32'h0, NEXT_PC});
    vecs.push_back('{"lw",   32'h8C220004, 1'b0, DEC, DEC | OP2_SEL_2 | alu(1), MEM_R, WB_RT | WD_SEL_1});
    vecs.push_back('{"sw",   32'hAC220004, 1'b0, DEC, DEC | OP2_SEL_2 | alu(1), MEM_W, NEXT_PC});
    vecs.push_back('{"jmp",  32'h08000010, 1'b0, DEC, DEC, 32'h0, PC_LOAD | PC_SEL_1});
    vecs.push_back('{"push", 32'h6C000000, 1'b0, REG_R, REG_R | OP1_SEL_1 | OP2_SEL_3 | alu(2),
                     MEM_W | MA_SEL_1 | MD_SEL_1, NEXT_PC | SP_LOAD});
    vecs.push_back('{"pop",  32'h70000000, 1'b0, DEC, DEC | OP1_SEL_1 | OP2_SEL_3 | alu(1) | SP_LOAD,
                     MEM_R | MA_SEL_1, NEXT_PC | REG_W | WD_SEL_1 | WD_SEL_3});
`ifndef CTRL_ILLEGAL_TRAP_EN
    vecs.push_back('{"undef_op", 32'hFC000000, 1'b0, DEC, DEC, 32'h0, NEXT_PC});
    vecs.push_back('{"undef_fn", 32'h0000003F, 1'b0, DEC, DEC, 32'h0, NEXT_PC});
`endif
    vecs.push_back('{"jal",  32'h0C000010, 1'b0, DEC, DEC, 32'h0, PC_LOAD | PC_SEL_1 | REG_W | WA_SEL_2});

    RST         = 1'b1;
    INSTRUCTION = 32'h0;
    ZERO        = 1'b0;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++)
      applyStimulus("reset_hold", 32'h00221820, 1'b1, 1'b1, 3'd0, 32'h0, 1'b0);

    for (int i = 0; i < vecs.size(); i++)
      runInstr(vecs[i]);

    // Reset during EXECUTE of the instruction after jal: abort, then a clean sw runs.
    applyStimulus("abort/fetch",   32'h00221820, 1'b0, 1'b0, 3'd0, FETCH_W, 1'b0);
    applyStimulus("abort/decode",  $urandom,     1'b0, 1'b0, 3'd1, DEC,     1'b0);
    applyStimulus("abort/execute", $urandom,     1'b1, 1'b1, 3'd2, 32'h0,   1'b0);
    applyStimulus("abort/refetch", 32'hAC220004, 1'b0, 1'b0, 3'd0, FETCH_W, 1'b0);
    applyStimulus("abort/decode2", $urandom,     1'b0, 1'b0, 3'd1, DEC,     1'b0);
    applyStimulus("abort/execute2", $urandom,    1'b0, 1'b0, 3'd2, DEC | OP2_SEL_2 | alu(1), 1'b0);
    applyStimulus("abort/memory2", $urandom,     1'b0, 1'b0, 3'd3, MEM_W,   1'b0);
    applyStimulus("abort/wb2",     $urandom,     1'b0, 1'b0, 3'd4, NEXT_PC, 1'b0);

`ifdef CTRL_ILLEGAL_TRAP_EN
    applyStimulus("trap/fetch",  32'hFC000000, 1'b0, 1'b0, 3'd0, FETCH_W, 1'b0);
    applyStimulus("trap/decode", $urandom,     1'b0, 1'b0, 3'd1, DEC,     1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus("trap/halt", $urandom, 1'b0, 1'b0, 3'd5, 32'h0, 1'b1);
    applyStimulus("trap/rst",     $urandom,     1'b0, 1'b1, 3'd5, 32'h0,   1'b1);
    applyStimulus("trap/recover", 32'h00221820, 1'b0, 1'b0, 3'd0, FETCH_W, 1'b0);
    applyStimulus("trap/decode2", $urandom,     1'b0, 1'b0, 3'd1, DEC,     1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
